mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Top-level mode controller for the digital clock module. Takes the three synchronized front-panel buttons (MODE, F1, F2), sequences the display mode (TIME, STW, ALARM, SET), and routes F1/F2 presses as single-cycle command pulses to whichever function owns the buttons in the current mode. In STW mode it drives the stopwatch control block, and in SET mode it drives the time-set datapath. Button hold time is measured with an external slow tick, which gives long-press and auto-repeat behaviour.

## Interface
- LONG_PRESS, 100: hold duration, in TICK strobes, that qualifies a long press.
- REPEAT, 20: interval, in TICK strobes, between auto-repeat SET_INC pulses.
- clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- TICK  input  1  one-cycle strobe from the prescaler (nominally 10 ms).
- SW_MODE, SW_F1, SW_F2  input  1 each  button levels, already synchronized and debounced; 1 = pressed.
- MODE  output  2  current mode: 0 TIME, 1 STW, 2 ALARM, 3 SET.
- STW_F1, STW_F2  output  1 each  one-cycle command pulses to the stopwatch control.
- ALM_TOGGLE  output  1  one-cycle pulse that toggles alarm enable.
- SET_FIELD  output  2  field being edited: 0 hours, 1 minutes, 2 seconds.
- SET_INC  output  1  one-cycle pulse that increments the selected field.
- SET_DONE  output  1  one-cycle pulse on exit from SET; commits the edited time.

## Operation
- Edge detection:
  - Each button has a previous-sample register.
  - press = level & ~prev; release = ~level & prev.
  - prev registers reset to 1, so a button held through reset must be released before it registers a press.
- MODE hold counter:
  - Counts TICKs while SW_MODE is high and saturates at LONG_PRESS.
  - Clears on any cycle where SW_MODE is low.
  - Width is clog2(LONG_PRESS+1).
- Mode FSM:
  - TIME → STW → ALARM → TIME, advancing on a SW_MODE release with hold count < LONG_PRESS.
  - TIME → SET when the hold count reaches LONG_PRESS. The following release is ignored (a long-press flag suppresses it).
  - In STW or ALARM, a long press does nothing and its release is ignored.
  - SET → TIME on a SW_MODE release (short or long), with a SET_DONE pulse.
  - On entry to SET, SET_FIELD = 0.
- F1/F2 routing:
  - TIME: F1 and F2 ignored.
  - STW: F1 press → STW_F1; F2 press → STW_F2.
  - ALARM: F1 press → ALM_TOGGLE; F2 ignored.
  - SET: F1 press → SET_FIELD advances 0→1→2→0 (wraps). F2 press → SET_INC.
- F2 auto-repeat in SET:
  - A second counter counts TICKs while SW_F2 is held.
  - Each time it reaches LONG_PRESS, one SET_INC is issued and the counter reloads to LONG_PRESS−REPEAT.
  - Result: first repeat at LONG_PRESS ticks after the press, then one every REPEAT ticks.
  - The counter clears when F2 is released or the mode leaves SET.
- Priority for events in the same cycle: MODE event > F2 > F1.
  - A mode change in a cycle suppresses that cycle's F1/F2 pulses.
  - F2 and F1 presses in the same SET cycle produce SET_INC only; the field does not advance.
- Pulse outputs are never high outside their owning mode. Changing mode mid-hold produces no stray STW_F*/SET_INC.

## Timing
- Reset values:
  - MODE = 0 and SET_FIELD = 0.
  - STW_F1, STW_F2, ALM_TOGGLE, SET_INC, SET_DONE = 0.
  - Hold counters = 0, long-press flag = 0, prev registers = 1.
- All outputs are registered.
- A press first sampled high at edge k drives its pulse high from edge k to edge k+1: exactly one cycle, independent of TICK.
- A MODE change decided at edge k is visible on MODE from edge k. SET_DONE is high in the same cycle as MODE returning to 0.
- Long press: TICKs are counted only while the button is high. Entry to SET occurs at the edge that samples the LONG_PRESS-th TICK.
- Reset mid-operation (any mode, held counters): all state returns to reset values on the next edge. No SET_DONE is issued.

## Test plan
Benches use LONG_PRESS=4 and REPEAT=2.
- Mode cycling: three short SW_MODE presses (held 1 TICK) → MODE steps 1, 2, 0. No pulses on STW_F*, ALM_TOGGLE or SET_*.
- Set entry and exit: hold SW_MODE for 6 TICKs in TIME → MODE=3 at the 4th TICK and stays 3 after release. Then F1 ×3 → SET_FIELD 1, 2, 0. Then a short MODE press → MODE=0 with a one-cycle SET_DONE.
- Auto-repeat: in SET, hold F2 for 9 TICKs → SET_INC at the press, at TICK 4, TICK 6 and TICK 8 (4 pulses). Release → no further pulses.
- Routing: in STW, F1 then F2 → one STW_F1 then one STW_F2. In ALARM, F1 → ALM_TOGGLE and F2 → nothing. In TIME, both → nothing.
- Simultaneous events: SW_MODE release plus F1 press in the same cycle while in STW → MODE=2 and no STW_F1. F1+F2 pressed together in SET → SET_INC only, SET_FIELD unchanged.
- Reset behaviour: assert reset while in SET with F2 held → all outputs reset next edge, no SET_DONE. Keep F2 held after reset → no pulse until F2 is released and pressed again.

Source files
------------

// File: rtl/mode_sequencer_if.sv
// Front-panel button levels and tick in; mode, field and
// single-cycle command pulses out.
interface mode_sequencer_if;
    logic       TICK;
    logic       SW_MODE;
    logic       SW_F1;
    logic       SW_F2;
    logic [1:0] MODE;
    logic       STW_F1;
    logic       STW_F2;
    logic       ALM_TOGGLE;
    logic [1:0] SET_FIELD;
    logic       SET_INC;
    logic       SET_DONE;

    modport master (
        output TICK, SW_MODE, SW_F1, SW_F2,
        input  MODE, STW_F1, STW_F2, ALM_TOGGLE,
        input  SET_FIELD, SET_INC, SET_DONE
    );

    modport slave (
        input  TICK, SW_MODE, SW_F1, SW_F2,
        output MODE, STW_F1, STW_F2, ALM_TOGGLE,
        output SET_FIELD, SET_INC, SET_DONE
    );
endinterface

// File: rtl/mode_sequencer.sv
// Display-mode sequencer: MODE button walks TIME/STW/ALARM, long
// press enters SET; F1/F2 presses become pulses for the owning mode.
module mode_sequencer #(
    parameter int LONG_PRESS = 100,
    parameter int REPEAT     = 20
) (
    input logic             clock,
    input logic             reset,
    mode_sequencer_if.slave bus
);
    localparam int CW = $clog2(LONG_PRESS + 1);
    localparam logic [CW-1:0] LP     = CW'(LONG_PRESS);
    localparam logic [CW-1:0] LP_M1  = CW'(LONG_PRESS - 1);
    localparam logic [CW-1:0] RELOAD = CW'(LONG_PRESS - REPEAT);

    typedef enum logic [1:0] {
        M_TIME  = 2'd0,
        M_STW   = 2'd1,
        M_ALARM = 2'd2,
        M_SET   = 2'd3
    } mode_e;

    mode_e         state_q, state_d;
    logic          prev_mode_q, prev_f1_q, prev_f2_q;
    logic          armed_q, armed_d;
    logic          long_q, long_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] rep_q, rep_d;
    logic [1:0]    field_q, field_d;
    logic          stw_f1_q, stw_f1_d;
    logic          stw_f2_q, stw_f2_d;
    logic          alm_q, alm_d;
    logic          inc_q, inc_d;
    logic          done_q, done_d;

    logic mode_press, mode_rel, f1_press, f2_press;
    logic tick_hold, long_hit, short_rel, mode_chg;
    logic rep_run, rep_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= M_TIME;
            prev_mode_q <= 1'b1;
            prev_f1_q   <= 1'b1;
            prev_f2_q   <= 1'b1;
            armed_q     <= 1'b0;
            long_q      <= 1'b0;
            hold_q      <= '0;
            rep_q       <= '0;
            field_q     <= 2'd0;
            stw_f1_q    <= 1'b0;
            stw_f2_q    <= 1'b0;
            alm_q       <= 1'b0;
            inc_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_mode_q <= bus.SW_MODE;
            prev_f1_q   <= bus.SW_F1;
            prev_f2_q   <= bus.SW_F2;
            armed_q     <= armed_d;
            long_q      <= long_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            field_q     <= field_d;
            stw_f1_q    <= stw_f1_d;
            stw_f2_q    <= stw_f2_d;
            alm_q       <= alm_d;
            inc_q       <= inc_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        long_d   = long_q;
        field_d  = field_q;
        stw_f1_d = 1'b0;
        stw_f2_d = 1'b0;
        alm_d    = 1'b0;
        inc_d    = 1'b0;
        done_d   = 1'b0;

        mode_press = bus.SW_MODE & ~prev_mode_q;
        mode_rel   = ~bus.SW_MODE & prev_mode_q;
        f1_press   = bus.SW_F1 & ~prev_f1_q;
        f2_press   = bus.SW_F2 & ~prev_f2_q;

        tick_hold = bus.SW_MODE && bus.TICK && (hold_q < LP);
        long_hit  = tick_hold && (hold_q == LP_M1);
        hold_d    = !bus.SW_MODE ? '0 :
                    tick_hold ? hold_q + 1'b1 : hold_q;

        // a release only counts if its press was seen after reset
        short_rel = mode_rel && armed_q && !long_q;
        if (mode_press) armed_d = 1'b1;
        if (mode_rel) begin
            armed_d = 1'b0;
            long_d  = 1'b0;
        end
        if (long_hit && state_q != M_SET) long_d = 1'b1;

        unique case (state_q)
            M_TIME: begin
                if (long_hit) begin
                    state_d = M_SET;
                    field_d = 2'd0;
                end else if (short_rel) begin
                    state_d = M_STW;
                end
            end
            M_STW:   if (short_rel) state_d = M_ALARM;
            M_ALARM: if (short_rel) state_d = M_TIME;
            M_SET: begin
                if (short_rel) begin
                    state_d = M_TIME;
                    done_d  = 1'b1;
                end
            end
        endcase

        mode_chg = (state_d != state_q);

        rep_run = bus.SW_F2 && state_q == M_SET && !mode_chg;
        rep_hit = rep_run && bus.TICK && (rep_q == LP_M1);
        if (!rep_run)
            rep_d = '0;
        else if (rep_hit)
            rep_d = RELOAD;
        else if (bus.TICK)
            rep_d = rep_q + 1'b1;
        else
            rep_d = rep_q;

        if (!mode_chg) begin
            unique case (state_q)
                M_TIME: ;
                M_STW: begin
                    stw_f1_d = f1_press;
                    stw_f2_d = f2_press;
                end
                M_ALARM: alm_d = f1_press;
                M_SET: begin
                    if (f2_press || rep_hit)
                        inc_d = 1'b1;
                    else if (f1_press)
                        field_d = (field_q == 2'd2) ? 2'd0
                                                    : field_q + 2'd1;
                end
            endcase
        end
    end

    assign bus.MODE       = state_q;
    assign bus.SET_FIELD  = field_q;
    assign bus.STW_F1     = stw_f1_q;
    assign bus.STW_F2     = stw_f2_q;
    assign bus.ALM_TOGGLE = alm_q;
    assign bus.SET_INC    = inc_q;
    assign bus.SET_DONE   = done_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer; pulse outputs are matched
// against a queue of expected pulses filled as stimulus is driven.
module tb_mode_sequencer;
    localparam logic [4:0] P_SF1  = 5'b10000;
    localparam logic [4:0] P_SF2  = 5'b01000;
    localparam logic [4:0] P_ALM  = 5'b00100;
    localparam logic [4:0] P_INC  = 5'b00010;
    localparam logic [4:0] P_DONE = 5'b00001;

    typedef struct {
        logic [4:0] p;
        logic [1:0] mode;
        logic [1:0] field;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic sm, s1, s2;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    mode_sequencer_if bus ();

    mode_sequencer #(.LONG_PRESS(4), .REPEAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic push(input logic [4:0] p, input logic [1:0] m,
                        input logic [1:0] f);
        exp_t e;
        e.p     = p;
        e.mode  = m;
        e.field = f;
        q.push_back(e);
    endtask

    task automatic cyc(input logic t);
        bus.TICK    = t;
        bus.SW_MODE = sm;
        bus.SW_F1   = s1;
        bus.SW_F2   = s2;
        @(posedge clock);
        #1;
    endtask

    task automatic short_mode();
        sm = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        sm = 1'b0;
        cyc(1'b0);
    endtask

    task automatic enter_set();
        sm = 1'b1;
        cyc(1'b0);
        repeat (4) cyc(1'b1);
        sm = 1'b0;
        cyc(1'b0);
    endtask

    task automatic chk_mode(input string tag, input int m);
        chk(tag, int'(bus.MODE), m);
    endtask

    always @(negedge clock) begin
        logic [4:0] p;
        exp_t       e;
        p = {bus.STW_F1, bus.STW_F2, bus.ALM_TOGGLE,
             bus.SET_INC, bus.SET_DONE};
        if (p != 5'd0) begin
            if (q.size() == 0) begin
                chk("stray_pulse", int'(p), 0);
            end else begin
                e = q.pop_front();
                chk("pulse", int'(p), int'(e.p));
                chk("pulse_mode", int'(bus.MODE), int'(e.mode));
                chk("pulse_field", int'(bus.SET_FIELD), int'(e.field));
            end
        end
    end

    initial begin
        reset = 1'b1;
        sm = 1'b0;
        s1 = 1'b0;
        s2 = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_mode("reset_mode", 0);
        chk("reset_field", int'(bus.SET_FIELD), 0);
        chk("reset_pulses", int'({bus.STW_F1, bus.STW_F2, bus.ALM_TOGGLE,
                                  bus.SET_INC, bus.SET_DONE}), 0);
        reset = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_mode("post_reset_idle", 0);

        for (int i = 1; i <= 3; i++) begin
            short_mode();
            chk_mode("cycle_mode", i % 3);
        end

        sm = 1'b1;
        cyc(1'b0);
        for (int t = 1; t <= 6; t++) begin
            cyc(1'b1);
            if (t == 3) chk_mode("set_before_lp", 0);
            if (t == 4) chk_mode("set_entry", 3);
            cyc(1'b0);
        end
        chk_mode("set_long_hold", 3);
        sm = 1'b0;
        cyc(1'b0);
        chk_mode("set_release_ignored", 3);
        chk("set_entry_field", int'(bus.SET_FIELD), 0);

        for (int j = 1; j <= 3; j++) begin
            s1 = 1'b1;
            cyc(1'b0);
            chk("field_step", int'(bus.SET_FIELD), j % 3);
            s1 = 1'b0;
            cyc(1'b0);
        end

        sm = 1'b1;
        cyc(1'b0);
        push(P_DONE, 2'd0, 2'd0);
        sm = 1'b0;
        cyc(1'b0);
        chk_mode("set_exit", 0);
        cyc(1'b0);

        enter_set();
        chk_mode("set_reentry", 3);
        s1 = 1'b1;
        cyc(1'b0);
        s1 = 1'b0;
        cyc(1'b0);
        chk("field_one", int'(bus.SET_FIELD), 1);
        s2 = 1'b1;
        push(P_INC, 2'd3, 2'd1);
        cyc(1'b0);
        for (int t = 1; t <= 9; t++) begin
            if (t == 4 || t == 6 || t == 8) push(P_INC, 2'd3, 2'd1);
            cyc(1'b1);
            cyc(1'b0);
        end
        s2 = 1'b0;
        repeat (6) cyc(1'b1);
        chk("repeat_drained", q.size(), 0);

        s1 = 1'b1;
        s2 = 1'b1;
        push(P_INC, 2'd3, 2'd1);
        cyc(1'b0);
        chk("f1f2_field_kept", int'(bus.SET_FIELD), 1);
        s1 = 1'b0;
        s2 = 1'b0;
        cyc(1'b0);
        sm = 1'b1;
        cyc(1'b0);
        push(P_DONE, 2'd0, 2'd1);
        sm = 1'b0;
        cyc(1'b0);
        chk_mode("set_exit2", 0);

        s1 = 1'b1;
        cyc(1'b0);
        s1 = 1'b0;
        cyc(1'b0);
        s2 = 1'b1;
        cyc(1'b0);
        s2 = 1'b0;
        cyc(1'b0);
        chk_mode("time_ignores_f", 0);

        short_mode();
        chk_mode("to_stw", 1);
        s1 = 1'b1;
        push(P_SF1, 2'd1, 2'd1);
        cyc(1'b0);
        s1 = 1'b0;
        cyc(1'b0);
        s2 = 1'b1;
        push(P_SF2, 2'd1, 2'd1);
        cyc(1'b0);
        s2 = 1'b0;
        cyc(1'b0);

        sm = 1'b1;
        cyc(1'b0);
        repeat (6) cyc(1'b1);
        sm = 1'b0;
        cyc(1'b0);
        chk_mode("stw_long_ignored", 1);

        sm = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        sm = 1'b0;
        s1 = 1'b1;
        cyc(1'b0);
        chk_mode("rel_plus_f1", 2);
        s1 = 1'b0;
        cyc(1'b0);

        s1 = 1'b1;
        push(P_ALM, 2'd2, 2'd1);
        cyc(1'b0);
        s1 = 1'b0;
        cyc(1'b0);
        s2 = 1'b1;
        cyc(1'b0);
        s2 = 1'b0;
        cyc(1'b0);
        chk_mode("alarm_stay", 2);
        short_mode();
        chk_mode("alarm_to_time", 0);

        enter_set();
        s1 = 1'b1;
        cyc(1'b0);
        s1 = 1'b0;
        cyc(1'b0);
        chk("pre_reset_field", int'(bus.SET_FIELD), 1);
        s2 = 1'b1;
        push(P_INC, 2'd3, 2'd1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        reset = 1'b1;
        cyc(1'b0);
        chk_mode("midop_reset_mode", 0);
        chk("midop_reset_field", int'(bus.SET_FIELD), 0);
        reset = 1'b0;
        repeat (3) cyc(1'b1);
        short_mode();
        chk_mode("held_f2_to_stw", 1);
        repeat (3) cyc(1'b1);
        s2 = 1'b0;
        cyc(1'b0);
        s2 = 1'b1;
        push(P_SF2, 2'd1, 2'd0);
        cyc(1'b0);
        s2 = 1'b0;
        cyc(1'b0);
        short_mode();
        short_mode();
        chk_mode("final_mode", 0);
        cyc(1'b0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
